// File: rtl/key_debounce_mc.sv
// Multi-channel key debouncer with press/release edges, long-press and auto-repeat.
// Each channel is an independent key_debounce_ch instance.

module key_debounce_ch #(
  parameter int DEB_CYCLES    = 480000,
  parameter int LONG_CYCLES   = 24000000,
  parameter int REPEAT_CYCLES = 4800000,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long,
  output logic key_repeat
);
  localparam logic RAW_IDLE = ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam int   DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int   HW = $clog2(LONG_CYCLES + 1);
  localparam int   RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
  localparam logic [RW-1:0] REP_LAST  = RW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, HELD, LONG} state_t;

  logic [1:0]    sync_pipe;
  logic [DW-1:0] deb_cnt;
  logic [HW-1:0] hold_cnt;
  logic [RW-1:0] rep_cnt;
  state_t        state;
  logic          pressed, mismatch, tog, rise, fall;

  assign pressed  = ACTIVE_LOW ? ~sync_pipe[1] : sync_pipe[1];
  assign mismatch = pressed ^ key_level;
  assign tog      = mismatch && (deb_cnt == DEB_LAST);
  assign rise     = tog & ~key_level;
  assign fall     = tog &  key_level;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_pipe   <= {2{RAW_IDLE}};
      deb_cnt     <= '0;
      hold_cnt    <= '0;
      rep_cnt     <= '0;
      state       <= IDLE;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
      key_repeat  <= 1'b0;
    end else begin
      sync_pipe   <= {sync_pipe[0], key};
      key_press   <= rise;
      key_release <= fall;
      key_long    <= 1'b0;
      key_repeat  <= 1'b0;

      if (!mismatch || tog) deb_cnt <= '0;
      else                  deb_cnt <= deb_cnt + DW'(1);
      if (tog) key_level <= ~key_level;

      // Release is checked first so it masks a long/repeat due on the same edge.
      if (fall) begin
        state    <= IDLE;
        hold_cnt <= '0;
        rep_cnt  <= '0;
      end else if (rise) begin
        state    <= HELD;
        hold_cnt <= '0;
        rep_cnt  <= '0;
      end else begin
        case (state)
          HELD: begin
            if (hold_cnt == HOLD_LAST) begin
              state    <= LONG;
              key_long <= 1'b1;
              hold_cnt <= HOLD_MAX;
              rep_cnt  <= '0;
            end else begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end
          LONG: begin
            if (REPEAT_CYCLES > 0) begin
              if (rep_cnt == REP_LAST) begin
                key_repeat <= 1'b1;
                rep_cnt    <= '0;
              end else begin
                rep_cnt <= rep_cnt + RW'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

module key_debounce_mc #(
  parameter int N             = 1,
  parameter int DEB_CYCLES    = 480000,
  parameter int LONG_CYCLES   = 24000000,
  parameter int REPEAT_CYCLES = 4800000,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] key,
  output logic [N-1:0] key_level,
  output logic [N-1:0] key_press,
  output logic [N-1:0] key_release,
  output logic [N-1:0] key_long,
  output logic [N-1:0] key_repeat
);
  key_debounce_ch #(
    .DEB_CYCLES   (DEB_CYCLES),
    .LONG_CYCLES  (LONG_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES),
    .ACTIVE_LOW   (ACTIVE_LOW)
  ) u_ch [N-1:0] (
    .clk        (clk),
    .rst_n      (rst_n),
    .key        (key),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long),
    .key_repeat (key_repeat)
  );
endmodule

// File: tb/tb_key_debounce_mc.sv
// Scoreboard bench: stimulus queues hand-computed output events per cycle, a negedge
// monitor pops and compares them and flags any pulse that was not scheduled.

module tb_key_debounce_mc;
  localparam int DEB = 4, LNG = 20, REP = 8;

  typedef struct {
    int cyc;
    logic [1:0] lvl, prs, rel, lng, rep;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] ka, kb;
  logic [1:0] a_lvl, a_prs, a_rel, a_lng, a_rep;
  logic [1:0] b_lvl, b_prs, b_rel, b_lng, b_rep;
  exp_t qa[$], qb[$];
  int cyc = 0;
  int tests = 0, fails = 0;

  key_debounce_mc #(.N(2), .DEB_CYCLES(DEB), .LONG_CYCLES(LNG),
                    .REPEAT_CYCLES(REP), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .key(ka), .key_level(a_lvl), .key_press(a_prs),
    .key_release(a_rel), .key_long(a_lng), .key_repeat(a_rep));

  key_debounce_mc #(.N(2), .DEB_CYCLES(DEB), .LONG_CYCLES(LNG),
                    .REPEAT_CYCLES(0), .ACTIVE_LOW(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .key(kb), .key_level(b_lvl), .key_press(b_prs),
    .key_release(b_rel), .key_long(b_lng), .key_repeat(b_rep));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic ea(input int c, input logic [1:0] lv, pr, rl, lg, rp);
    exp_t e;
    e.cyc = c; e.lvl = lv; e.prs = pr; e.rel = rl; e.lng = lg; e.rep = rp;
    qa.push_back(e);
  endtask

  task automatic eb(input int c, input logic [1:0] lv, pr, rl, lg, rp);
    exp_t e;
    e.cyc = c; e.lvl = lv; e.prs = pr; e.rel = rl; e.lng = lg; e.rep = rp;
    qb.push_back(e);
  endtask

  task automatic scan(input int d, input logic [1:0] lv, pr, rl, lg, rp);
    exp_t e;
    int   n;
    n = (d == 0) ? qa.size() : qb.size();
    while (n > 0) begin
      e = (d == 0) ? qa[0] : qb[0];
      if (e.cyc >= cyc) break;
      tests++; fails++;
      $display("FAIL dut%0d missed_event @%0d: expected event not seen by cycle %0d", d, e.cyc, cyc);
      if (d == 0) void'(qa.pop_front()); else void'(qb.pop_front());
      n--;
    end
    if (n > 0 && e.cyc == cyc) begin
      if (d == 0) void'(qa.pop_front()); else void'(qb.pop_front());
      tests++;
      if ({lv, pr, rl, lg, rp} !== {e.lvl, e.prs, e.rel, e.lng, e.rep}) begin
        fails++;
        $display("FAIL dut%0d event @%0d: got lvl=%b prs=%b rel=%b lng=%b rep=%b, expected lvl=%b prs=%b rel=%b lng=%b rep=%b",
                 d, cyc, lv, pr, rl, lg, rp, e.lvl, e.prs, e.rel, e.lng, e.rep);
      end
    end else if ((pr | rl | lg | rp) != 2'b00) begin
      tests++; fails++;
      $display("FAIL dut%0d unexpected_pulse @%0d: got prs=%b rel=%b lng=%b rep=%b, expected none",
               d, cyc, pr, rl, lg, rp);
    end
  endtask

  always @(negedge clk) begin
    if (cyc >= 1) begin
      scan(0, a_lvl, a_prs, a_rel, a_lng, a_rep);
      scan(1, b_lvl, b_prs, b_rel, b_lng, b_rep);
    end
  end

  task automatic at_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; ka = 2'b11; kb = 2'b11;

    // Reset state after edges 1 and 2.
    ea(2, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    eb(2, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    // Clean press sampled from edge 6 -> press at 11, long 31, repeats 39/47/55.
    // Release sampled from edge 58 lands at 63, same edge as the next repeat: release wins.
    ea(11, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
    ea(12, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    ea(31, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00);
    ea(39, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
    ea(47, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
    ea(55, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
    ea(63, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
    // Bounce: level must stay low.
    ea(96, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    // Short hold: press 106, release 122, long (126) never reached.
    ea(106, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
    ea(122, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
    // Repeat disabled: press 136, long 156, release 182, no repeats.
    eb(136, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
    eb(156, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00);
    eb(182, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
    // Reset mid-hold: press 196, reset edge 201 clears, re-press 6 edges later at 207.
    ea(196, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
    ea(201, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    eb(201, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    ea(207, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
    ea(216, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
    // Both channels together: press 226, long 246, repeat 254, release 262 masks repeat.
    ea(226, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00);
    ea(246, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00);
    ea(254, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11);
    ea(262, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);

    at_cyc(2);  rst_n = 1'b1;
    at_cyc(5);  ka[0] = 1'b0;
    at_cyc(57); ka[0] = 1'b1;

    // Low runs of 3 samples are one short of what the debouncer can accept.
    for (int r = 0; r < 4; r++) begin
      at_cyc(72 + 4 * r); ka[0] = 1'b0;
      at_cyc(75 + 4 * r); ka[0] = 1'b1;
    end

    at_cyc(100); ka[0] = 1'b0;
    at_cyc(116); ka[0] = 1'b1;

    at_cyc(130); kb[0] = 1'b0;
    at_cyc(176); kb[0] = 1'b1;

    at_cyc(190); ka[0] = 1'b0;
    at_cyc(200); rst_n = 1'b0;
    at_cyc(201); rst_n = 1'b1;
    at_cyc(210); ka[0] = 1'b1;

    at_cyc(220); ka = 2'b00;
    at_cyc(256); ka = 2'b11;

    at_cyc(280);
    while (qa.size() > 0) begin
      tests++; fails++;
      $display("FAIL dut0 leftover_event @%0d: never observed", qa[0].cyc);
      void'(qa.pop_front());
    end
    while (qb.size() > 0) begin
      tests++; fails++;
      $display("FAIL dut1 leftover_event @%0d: never observed", qb[0].cyc);
      void'(qb.pop_front());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
